// File: rtl/vqueue_fetch_pkg.sv
// vqueue_fetch_pkg: state encoding and default geometry for the video queue fetcher.
package vqueue_fetch_pkg;
   typedef enum logic [1:0] {IDLE, CHECK, REQ, RECV} state_t;
   localparam int ADDR_WIDTH = 11;
   localparam int BURST_LEN = 8;
   localparam int ADDR_BITS = 22;
   localparam int FB_BASE = 0;
   localparam int FRAME_WORDS = 24576;
   localparam int QDEPTH = 2 ** ADDR_WIDTH;
   localparam int BURSTS_PER_FRAME = FRAME_WORDS / BURST_LEN;
endpackage

// File: rtl/vqueue_credit.sv
// vqueue_credit: saturating queue credit counter (reserve a burst, release on consume/discard).
module vqueue_credit #(
   parameter int addr_width = 11,
   parameter int burst_len = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reserve,
   input  logic                consume,
   input  logic                discard,
   output logic [addr_width:0] level
);
   localparam int LW = addr_width + 1;
   logic [LW:0] up, dn;
   logic [LW-1:0] nxt;
   always_comb begin
      up = {1'b0, level} + (reserve ? (LW+1)'(burst_len) : '0);
      dn = (LW+1)'(consume) + (LW+1)'(discard);
      nxt = up < dn ? '0 : LW'(up - dn);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) level <= '0;
      else level <= nxt;
endmodule

// File: rtl/vqueue_fetch.sv
// vqueue_fetch: issues SDRAM burst reads over the framebuffer and feeds the video queue,
// requesting only when a whole burst is guaranteed to fit.
module vqueue_fetch
   import vqueue_fetch_pkg::*;
#(
   parameter int addr_width = ADDR_WIDTH,
   parameter int burst_len = BURST_LEN,
   parameter int addr_bits = ADDR_BITS,
   parameter int fb_base = FB_BASE,
   parameter int frame_words = FRAME_WORDS
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 FrameStart,
   input  logic                 Consume,
   output logic                 MemReq,
   output logic [addr_bits-1:0] MemAddr,
   input  logic                 MemAck,
   input  logic                 MemValid,
   input  logic [31:0]          MemData,
   output logic                 WrEn,
   output logic [31:0]          Data,
   output logic [addr_width:0]  Level,
   output logic                 Busy
);
   localparam int QD = 2 ** addr_width;
   localparam int LW = addr_width + 1;
   localparam int PW = $clog2(frame_words + 1);
   localparam int CW = $clog2(burst_len + 1);
   state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n;
   logic [CW-1:0] cnt, cnt_n;
   logic pend, pend_n, req_n, wr_n, reserve, discard;
   logic [addr_bits-1:0] addr_n;
   logic [31:0] data_n;
   vqueue_credit #(.addr_width(addr_width), .burst_len(burst_len)) credit (
      .clk(Clock), .rst(Reset), .reserve(reserve), .consume(Consume),
      .discard(discard), .level(Level)
   );
   assign Busy = state != IDLE;
   always_ff @(posedge Clock or posedge Reset)
      if (Reset) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         pend <= 1'b0;
         MemReq <= 1'b0;
         MemAddr <= addr_bits'(fb_base);
         WrEn <= 1'b0;
         Data <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         cnt <= cnt_n;
         pend <= pend_n;
         MemReq <= req_n;
         MemAddr <= addr_n;
         WrEn <= wr_n;
         Data <= data_n;
      end
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      cnt_n = cnt;
      pend_n = pend;
      req_n = MemReq;
      addr_n = MemAddr;
      wr_n = 1'b0;
      data_n = Data;
      reserve = 1'b0;
      discard = 1'b0;
      case (state)
         IDLE: if (FrameStart) begin
            ptr_n = '0;
            state_n = CHECK;
         end
         CHECK: if (FrameStart) ptr_n = '0;
         else if (ptr == PW'(frame_words)) state_n = IDLE;
         else if (Level <= LW'(QD - burst_len)) begin
            req_n = 1'b1;
            addr_n = addr_bits'(fb_base) + addr_bits'(ptr);
            state_n = REQ;
         end
         REQ: if (MemAck) begin
            req_n = 1'b0;
            reserve = 1'b1;
            ptr_n = ptr + PW'(burst_len);
            cnt_n = '0;
            pend_n = FrameStart;
            state_n = RECV;
         end else if (FrameStart) begin
            req_n = 1'b0;
            ptr_n = '0;
            state_n = CHECK;
         end
         RECV: begin
            if (FrameStart) pend_n = 1'b1;
            if (MemValid) begin
               // a restart turns the rest of the burst into credit releases instead of writes
               discard = pend | FrameStart;
               wr_n = ~discard;
               data_n = discard ? Data : MemData;
               cnt_n = cnt + CW'(1);
               if (cnt == CW'(burst_len - 1)) begin
                  state_n = CHECK;
                  ptr_n = discard ? '0 : ptr;
                  pend_n = 1'b0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_vqueue_fetch.sv
// tb_vqueue_fetch: directed bench for the video queue fetcher with hand-computed expectations.
module tb_vqueue_fetch;
   import vqueue_fetch_pkg::*;
   logic Clock = 1'b0, Reset = 1'b1, FrameStart = 1'b0, Consume = 1'b0;
   logic MemAck = 1'b0, MemValid = 1'b0;
   logic [31:0] MemData = '0;
   logic MemReq, WrEn, Busy;
   logic [21:0] MemAddr;
   logic [31:0] Data;
   logic [11:0] Level;
   int checks = 0, passes = 0, acc = 0, acc0;
   bit ok;
   vqueue_fetch dut (
      .Clock(Clock), .Reset(Reset), .FrameStart(FrameStart), .Consume(Consume),
      .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemValid(MemValid),
      .MemData(MemData), .WrEn(WrEn), .Data(Data), .Level(Level), .Busy(Busy)
   );
   always #5 Clock = ~Clock;
   always @(posedge Clock) if (MemReq && MemAck) acc <= acc + 1;
   task automatic tick;
      @(posedge Clock);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic wait_req(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i <= budget && !seen; i++)
         if (MemReq) seen = 1'b1;
         else tick();
   endtask
   task automatic burst(input logic [21:0] ea);
      bit s;
      logic [31:0] pat;
      wait_req(10, s);
      check("req_seen", 32'(s), 1);
      check("addr", 32'(MemAddr), 32'(ea));
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      check("req_drop", 32'(MemReq), 0);
      for (int i = 0; i < 8; i++) begin
         pat = 32'hA500_0000 + (32'(ea) << 4) + 32'(i);
         MemValid = 1'b1;
         MemData = pat;
         tick();
         check("wr_en", 32'(WrEn), 1);
         check("data", Data, pat);
      end
      MemValid = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      check("rst_req", 32'(MemReq), 0);
      check("rst_addr", 32'(MemAddr), 0);
      check("rst_wr", 32'(WrEn), 0);
      check("rst_data", Data, 0);
      check("rst_level", 32'(Level), 0);
      check("rst_busy", 32'(Busy), 0);
      Reset = 1'b0;
      tick();
      FrameStart = 1'b1;
      tick();
      FrameStart = 1'b0;
      check("busy", 32'(Busy), 1);
      for (int k = 0; k < 256; k++) burst(22'(k * 8));
      check("full_level", 32'(Level), 2048);
      repeat (5) tick();
      check("full_stop", 32'(MemReq), 0);
      for (int i = 0; i < 8; i++) begin
         Consume = 1'b1;
         tick();
      end
      Consume = 1'b0;
      check("level_2040", 32'(Level), 2040);
      wait_req(2, ok);
      check("req_after_room", 32'(ok), 1);
      burst(22'd2048);
      check("refull", 32'(Level), 2048);
      Consume = 1'b1;
      for (int i = 0; i < 3000 && Level != 100; i++) tick();
      check("level_100", 32'(Level), 100);
      check("req_pending", 32'(MemReq), 1);
      check("addr_2056", 32'(MemAddr), 2056);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      Consume = 1'b0;
      check("ack_consume", 32'(Level), 107);
      for (int i = 0; i < 8; i++) begin
         MemValid = 1'b1;
         MemData = 32'h1000 + 32'(i);
         tick();
         check("wr_en2", 32'(WrEn), 1);
         check("data2", Data, 32'h1000 + 32'(i));
      end
      MemValid = 1'b0;
      Consume = 1'b1;
      for (int i = 0; i < 200 && Level != 0; i++) tick();
      tick();
      Consume = 1'b0;
      check("sat_zero", 32'(Level), 0);
      check("req_2064", 32'(MemReq), 1);
      check("addr_2064", 32'(MemAddr), 2064);
      FrameStart = 1'b1;
      tick();
      FrameStart = 1'b0;
      check("abort_req", 32'(MemReq), 0);
      check("abort_level", 32'(Level), 0);
      wait_req(3, ok);
      check("restart_req", 32'(ok), 1);
      check("restart_addr", 32'(MemAddr), 0);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      check("level_8", 32'(Level), 8);
      for (int i = 0; i < 3; i++) begin
         MemValid = 1'b1;
         MemData = 32'h77 + 32'(i);
         tick();
         check("kept_wr", 32'(WrEn), 1);
      end
      MemValid = 1'b0;
      FrameStart = 1'b1;
      tick();
      FrameStart = 1'b0;
      check("gap_wr", 32'(WrEn), 0);
      for (int i = 0; i < 5; i++) begin
         MemValid = 1'b1;
         tick();
         check("discard_wr", 32'(WrEn), 0);
      end
      MemValid = 1'b0;
      check("discard_level", 32'(Level), 3);
      wait_req(3, ok);
      check("post_discard_req", 32'(ok), 1);
      check("post_discard_addr", 32'(MemAddr), 0);
      MemAck = 1'b1;
      tick();
      MemAck = 1'b0;
      for (int i = 0; i < 2; i++) begin
         MemValid = 1'b1;
         MemData = 32'hBEEF;
         tick();
      end
      Reset = 1'b1;
      #1;
      check("arst_req", 32'(MemReq), 0);
      check("arst_addr", 32'(MemAddr), 0);
      check("arst_wr", 32'(WrEn), 0);
      check("arst_data", Data, 0);
      check("arst_level", 32'(Level), 0);
      check("arst_busy", 32'(Busy), 0);
      for (int i = 0; i < 4; i++) begin
         MemValid = ~MemValid;
         tick();
      end
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         MemValid = ~MemValid;
         tick();
         check("post_rst_wr", 32'(WrEn), 0);
      end
      MemValid = 1'b0;
      check("post_rst_busy", 32'(Busy), 0);
      Consume = 1'b1;
      acc0 = acc;
      FrameStart = 1'b1;
      tick();
      FrameStart = 1'b0;
      for (int k = 0; k < BURSTS_PER_FRAME; k++) burst(22'(k * 8));
      check("last_addr", 32'(MemAddr), 24568);
      tick();
      check("frame_idle", 32'(Busy), 0);
      check("accepts", 32'(acc - acc0), 3072);
      wait_req(20, ok);
      check("no_more_req", 32'(ok), 0);
      Consume = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
